dmem_bridge: RTL and testbench

- Data-memory stage partner of the pipelined MIPS core. Consumes the core's memory-stage outputs (address, write data, write enable) and produces readdata.
- Converts the core's single-cycle data access into a req/ack bus handshake with variable wait states.
- Posts stores through a one-entry write buffer, stalls the pipeline on loads and buffer conflicts, and aborts bus transactions that time out.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_wbuf.sv | 41 ++++
 rtl/dmem_bridge.sv | 186 ++++++++++++++++++
 tb/tb_dmem_bridge.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory bridge.
//   dmemState_t        : bridge FSM states
//   WORD_W             : data/address width
//   WORD_MASK          : clears the byte offset of a byte address
//   DEF_TIMEOUT_CYCLES : default bus-wait limit before abort
//   wordAddr()         : byte address -> word-aligned address
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUS  = 2'd1,
    RD_BUS  = 2'd2,
    RD_DONE = 2'd3
  } dmemState_t;

  function automatic logic [WORD_W-1:0] wordAddr(input logic [WORD_W-1:0] a);
    return a & WORD_MASK;
  endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: single-entry posted-store buffer.
//   clk, reset (async, active-low)
//   capture    : load capAddr/capData, mark valid (wins over invalidate)
//   invalidate : drop the entry once its bus write has finished or aborted
//   cmpAddr    : address compared at word granularity -> hit
//   valid/addr/data : current entry (addr is word aligned)
module dmem_wbuf
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic              invalidate,
  input  logic [WORD_W-1:0] capAddr,
  input  logic [WORD_W-1:0] capData,
  input  logic [WORD_W-1:0] cmpAddr,
  output logic              valid,
  output logic [WORD_W-1:0] addr,
  output logic [WORD_W-1:0] data,
  output logic              hit
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (capture) begin
      // A stalled store is captured in the same cycle its predecessor's
      // drain completes, so capture must override invalidate.
      valid <= 1'b1;
      addr  <= wordAddr(capAddr);
      data  <= capData;
    end else if (invalidate) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (addr == wordAddr(cmpAddr));

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: memory-stage bridge between the pipelined MIPS core and a
// req/ack data bus. Stores are posted through a one-entry buffer, loads
// stall the core until data returns, and bus waits longer than
// TIMEOUT_CYCLES are aborted (0 disables the timeout).
//   cpu_en/cpu_we/cpu_addr/cpu_wdata : core access (held while cpu_stall)
//   cpu_rdata, cpu_stall              : combinational core responses
//   bus_req/bus_we/bus_addr/bus_wdata : registered bus request
//   bus_rdata, bus_ack                : bus response
//   bus_err                           : one-cycle pulse on timeout abort
//   align_err                         : only with DMEM_ALIGN_CHECK_EN defined;
//                                       pulse after a suppressed misaligned access
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [WORD_W-1:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic [WORD_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [WORD_W-1:0] bus_addr,
  output logic [WORD_W-1:0] bus_wdata,
  input  logic [WORD_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic              align_err
`endif
);

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [WORD_W-1:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : '0;

  dmemState_t        state, stateNext;
  logic              reqNext, weNext, errNext;
  logic [WORD_W-1:0] addrNext, wdataNext;
  logic [WORD_W-1:0] rdataQ, rdataNext;
  logic [WORD_W-1:0] toCnt, cntNext;
  logic              capture, invalidate;
  logic              bufValid, bufHit;
  logic [WORD_W-1:0] bufAddr, bufData;
  logic              misaligned, isLoad, isStore, ackIn, expire;
  logic              stall;
  logic [WORD_W-1:0] rdataOut;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = cpu_en && (cpu_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign isStore = cpu_en &&  cpu_we && !misaligned;
  assign isLoad  = cpu_en && !cpu_we && !misaligned;
  assign ackIn   = bus_req && bus_ack;
  // toCnt holds completed waiting cycles, so the last allowed cycle is TO_LAST.
  assign expire  = TO_EN && bus_req && !bus_ack && (toCnt == TO_LAST);

  dmem_wbuf wbuf (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture),
    .invalidate(invalidate),
    .capAddr   (cpu_addr),
    .capData   (cpu_wdata),
    .cmpAddr   (cpu_addr),
    .valid     (bufValid),
    .addr      (bufAddr),
    .data      (bufData),
    .hit       (bufHit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_err   <= 1'b0;
      rdataQ    <= '0;
      toCnt     <= '0;
    end else begin
      state     <= stateNext;
      bus_req   <= reqNext;
      bus_we    <= weNext;
      bus_addr  <= addrNext;
      bus_wdata <= wdataNext;
      bus_err   <= errNext;
      rdataQ    <= rdataNext;
      toCnt     <= cntNext;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) align_err <= 1'b0;
    else        align_err <= misaligned;
  end
`endif

  always_comb begin
    stateNext  = state;
    reqNext    = bus_req;
    weNext     = bus_we;
    addrNext   = bus_addr;
    wdataNext  = bus_wdata;
    errNext    = 1'b0;
    rdataNext  = rdataQ;
    cntNext    = (bus_req && !bus_ack) ? toCnt + 32'd1 : toCnt;
    capture    = 1'b0;
    invalidate = 1'b0;
    stall      = 1'b0;
    rdataOut   = rdataQ;

    // Bus side. Ack is tested before expiry so a coincident ack wins.
    case (state)
      IDLE: begin
        if (bufValid) begin
          stateNext = WR_BUS;
          reqNext   = 1'b1;
          weNext    = 1'b1;
          addrNext  = bufAddr;
          wdataNext = bufData;
          cntNext   = '0;
        end else if (isLoad) begin
          stateNext = RD_BUS;
          reqNext   = 1'b1;
          weNext    = 1'b0;
          addrNext  = wordAddr(cpu_addr);
          cntNext   = '0;
        end
      end
      WR_BUS: begin
        if (ackIn || expire) begin
          stateNext  = IDLE;
          reqNext    = 1'b0;
          invalidate = 1'b1;
          errNext    = !ackIn;
          cntNext    = '0;
        end
      end
      RD_BUS: begin
        if (ackIn || expire) begin
          stateNext = RD_DONE;
          reqNext   = 1'b0;
          rdataNext = ackIn ? bus_rdata : ERR_RDATA;
          errNext   = !ackIn;
          cntNext   = '0;
        end
      end
      RD_DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    // Core side.
    if (state == RD_DONE) begin
      rdataOut = rdataQ;
    end else if (misaligned) begin
      rdataOut = ERR_RDATA;
    end else if (isStore) begin
      capture = (state == IDLE && !bufValid) || (state == WR_BUS && ackIn);
      stall   = !capture;
    end else if (isLoad) begin
      if (bufHit) rdataOut = bufData;
      else        stall    = 1'b1;
    end

    // The core sees a quiet bridge for as long as reset is held.
    if (!reset) begin
      stall    = 1'b0;
      rdataOut = '0;
    end
  end

  assign cpu_stall = stall;
  assign cpu_rdata = rdataOut;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: self-checking bench for dmem_bridge. Directed scenarios
// followed by randomized loads/stores checked against a word-addressed
// reference memory kept in program order, with a bus slave model of
// random wait states and a bus monitor checking transaction order.
module tb_dmem_bridge;

  localparam int unsigned TO   = 4;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;
  localparam logic [31:0] MASK = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_en = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_req, bus_we, bus_err;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  dmem_bridge #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERRV)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_en   (cpu_en),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack  (bus_ack),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference memory (program order) and slave memory (bus-visible).
  logic [31:0] refMem   [logic [31:0]];
  logic [31:0] slaveMem [logic [31:0]];
  logic [63:0] expWrites[$];
  logic [32:0] txnLog[$];

  function automatic logic [31:0] initVal(input logic [31:0] a);
    return a ^ 32'h5EED_0000;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    if (refMem.exists(a & MASK)) return refMem[a & MASK];
    return initVal(a & MASK);
  endfunction

  // Slave controls and monitor results.
  int          fixedLat = -1;
  bit          noAck = 1'b0;
  bit          spuriousAck = 1'b0;
  int          readCount = 0;
  int          busErrPulses = 0;
  int          lastReqCycles = 0;
  logic [31:0] curLoadAddr = '0;

  // Bus slave: acks after slvLat extra cycles (0 = first request cycle).
  initial begin
    bit slvActive = 1'b0;
    int slvCnt = 0;
    int slvLat = 0;
    forever begin
      @(posedge clk);
      #1;
      bus_ack = 1'b0;
      if (!reset) begin
        slvActive = 1'b0;
      end else if (spuriousAck) begin
        bus_ack     = 1'b1;
        bus_rdata   = $urandom;
        spuriousAck = 1'b0;
      end else if (bus_req) begin
        if (!slvActive) begin
          slvActive = 1'b1;
          slvCnt    = 0;
          slvLat    = (fixedLat >= 0) ? fixedLat : int'($urandom_range(0, 3));
        end
        if (!noAck && slvCnt == slvLat) begin
          bus_ack = 1'b1;
          if (bus_we) slaveMem[bus_addr] = bus_wdata;
          else bus_rdata = slaveMem.exists(bus_addr) ? slaveMem[bus_addr] : initVal(bus_addr);
        end
        slvCnt++;
      end else begin
        slvActive = 1'b0;
      end
    end
  end

  // Bus monitor, sampled on the falling edge.
  initial begin
    bit          prevReq = 1'b0;
    int          reqCycles = 0;
    logic        riseWe;
    logic [31:0] riseAddr, riseWdata;
    logic [63:0] w;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prevReq   = 1'b0;
        reqCycles = 0;
      end else begin
        if (bus_req && !prevReq) begin
          reqCycles = 0;
          riseWe    = bus_we;
          riseAddr  = bus_addr;
          riseWdata = bus_wdata;
          txnLog.push_back({bus_we, bus_addr});
          checkVal("busAddrLow", {30'd0, bus_addr[1:0]}, 32'd0);
          if (bus_we) begin
            checkVal("wrPending", {31'd0, expWrites.size() > 0}, 32'd1);
            if (expWrites.size() > 0) begin
              w = expWrites.pop_front();
              checkVal("wrAddr", bus_addr, w[63:32]);
              checkVal("wrData", bus_wdata, w[31:0]);
            end
          end else begin
            readCount++;
            checkVal("rdAddr", bus_addr, curLoadAddr & MASK);
          end
        end
        if (bus_req) begin
          reqCycles++;
          if (bus_ack) begin
            checkVal("stableAddr", bus_addr, riseAddr);
            checkVal("stableData", bus_wdata, riseWdata);
            checkVal("stableWe", {31'd0, bus_we}, {31'd0, riseWe});
          end
        end
        if (prevReq && !bus_req) lastReqCycles = reqCycles;
        if (bus_err) busErrPulses++;
        prevReq = bus_req;
      end
    end
  end

  // Core access; call at posedge+1, returns at posedge+1 after retirement.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int stallCycles);
    bit done;
    done        = 1'b0;
    stallCycles = 0;
    rdata       = '0;
    cpu_en      = 1'b1;
    cpu_we      = we;
    cpu_addr    = addr;
    cpu_wdata   = wdata;
    if (!we) curLoadAddr = addr;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (cpu_stall) begin
        stallCycles++;
      end else begin
        done  = 1'b1;
        rdata = cpu_rdata;
        if (we) begin
          refMem[addr & MASK] = wdata;
          expWrites.push_back({addr & MASK, wdata});
        end
      end
    end
    if (!done) checkVal("stallBound", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk);
    #1;
    cpu_en = 1'b0;
    cpu_we = 1'b0;
  endtask

  task automatic idle(input int n);
    cpu_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a, wd, expv;
    logic [32:0] t;
    int          sc, e0, r0, n0;

    // Reset state, with a load presented to check stall gating.
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1234;
    repeat (2) @(negedge clk);
    checkVal("rstReq",   {31'd0, bus_req}, 32'd0);
    checkVal("rstWe",    {31'd0, bus_we}, 32'd0);
    checkVal("rstAddr",  bus_addr, 32'd0);
    checkVal("rstWdata", bus_wdata, 32'd0);
    checkVal("rstErr",   {31'd0, bus_err}, 32'd0);
    checkVal("rstStall", {31'd0, cpu_stall}, 32'd0);
    checkVal("rstRdata", cpu_rdata, 32'd0);
    cpu_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 1: posted store, ack in the 4th request cycle (coincides with timeout).
    fixedLat = 3; e0 = busErrPulses;
    access(1'b1, 32'h1000, 32'hA5A5_A5A5, rd, sc);
    checkVal("t1Stall", 32'(sc), 32'd0);
    idle(8);
    checkVal("t1ReqCycles", 32'(lastReqCycles), 32'd4);
    t = txnLog[txnLog.size() - 1];
    checkVal("t1TxnWe", {31'd0, t[32]}, 32'd1);
    checkVal("t1TxnAddr", t[31:0], 32'h1000);
    checkVal("t1NoErr", 32'(busErrPulses), 32'(e0));
    fixedLat = 0; r0 = readCount;
    access(1'b0, 32'h1000, 32'd0, rd, sc);
    checkVal("t1BufEmpty", 32'(readCount), 32'(r0 + 1));
    checkVal("t1LoadData", rd, 32'hA5A5_A5A5);

    // 2: load forwarded from the buffer before its drain completes.
    fixedLat = 3; r0 = readCount;
    access(1'b1, 32'h2000, 32'h1111_1111, rd, sc);
    access(1'b0, 32'h2002, 32'd0, rd, sc);
    checkVal("t2Stall", 32'(sc), 32'd0);
    checkVal("t2Fwd", rd, 32'h1111_1111);
    idle(8);
    checkVal("t2NoRead", 32'(readCount), 32'(r0));

    // 3: load to a different word drains first, then reads.
    fixedLat = 2;
    slaveMem[32'h3004] = 32'hCAFE_F00D;
    refMem[32'h3004]   = 32'hCAFE_F00D;
    n0 = txnLog.size();
    access(1'b1, 32'h3000, 32'h3333_3333, rd, sc);
    access(1'b0, 32'h3004, 32'd0, rd, sc);
    checkVal("t3StallCycles", 32'(sc), 32'd8);
    checkVal("t3Data", rd, 32'hCAFE_F00D);
    checkVal("t3TxnCount", 32'(txnLog.size() - n0), 32'd2);
    if (txnLog.size() >= n0 + 2) begin
      t = txnLog[n0];
      checkVal("t3FirstWrite", {t[32], t[30:0]}, {1'b1, 31'h3000});
      t = txnLog[n0 + 1];
      checkVal("t3ThenRead", {t[32], t[30:0]}, {1'b0, 31'h3004});
    end

    // 4: back-to-back stores; the second waits for the first ack.
    fixedLat = 1; n0 = txnLog.size();
    access(1'b1, 32'h40, 32'h4040_4040, rd, sc);
    checkVal("t4FirstStall", 32'(sc), 32'd0);
    access(1'b1, 32'h44, 32'h4444_4444, rd, sc);
    checkVal("t4SecondStall", 32'(sc), 32'd2);
    idle(8);
    checkVal("t4TxnCount", 32'(txnLog.size() - n0), 32'd2);
    if (txnLog.size() >= n0 + 2) begin
      t = txnLog[n0];
      checkVal("t4Write1", t[31:0], 32'h40);
      t = txnLog[n0 + 1];
      checkVal("t4Write2", t[31:0], 32'h44);
    end

    // 5: read timeout.
    noAck = 1'b1; e0 = busErrPulses;
    access(1'b0, 32'h50, 32'd0, rd, sc);
    checkVal("t5Data", rd, ERRV);
    checkVal("t5StallCycles", 32'(sc), 32'd5);
    idle(2);
    checkVal("t5ErrPulse", 32'(busErrPulses), 32'(e0 + 1));
    checkVal("t5ReqCycles", 32'(lastReqCycles), 32'd4);
    checkVal("t5ReqLow", {31'd0, bus_req}, 32'd0);

    // 6: asynchronous reset while a read is waiting.
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h60; curLoadAddr = 32'h60;
    repeat (3) @(negedge clk);
    checkVal("t6InRead", {31'd0, bus_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    checkVal("t6ReqDrop", {31'd0, bus_req}, 32'd0);
    checkVal("t6Stall", {31'd0, cpu_stall}, 32'd0);
    checkVal("t6Rdata", cpu_rdata, 32'd0);
    cpu_en = 1'b0; noAck = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    e0 = busErrPulses; r0 = readCount;
    spuriousAck = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkVal("t6IgnoreAck", {31'd0, bus_req}, 32'd0);
    end
    @(posedge clk);
    #1;
    fixedLat = 0;
    access(1'b0, 32'h60, 32'd0, rd, sc);
    checkVal("t6LoadAfter", rd, refRead(32'h60));
    checkVal("t6LoadLatency", 32'(sc), 32'd2);
    checkVal("t6ErrQuiet", 32'(busErrPulses), 32'(e0));

    // Randomized mix over a few words with random byte offsets and waits.
    fixedLat = -1; e0 = busErrPulses;
    for (int i = 0; i < 150; i++) begin
      a = 32'h100 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        access(1'b1, a, wd, rd, sc);
      end else begin
        expv = refRead(a);
        access(1'b0, a, 32'd0, rd, sc);
        checkVal("rndLoad", rd, expv);
      end
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(10);
    checkVal("rndDrained", 32'(expWrites.size()), 32'd0);
    checkVal("rndNoErr", 32'(busErrPulses), 32'(e0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
